instr_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the instruction decoder and execution datapath. It fetches each instruction through a request/ready handshake and holds it in an instruction register that drives the `InstructionDecoder`. It latches the decoded controls, then issues register-file read, ALU execute and write-back strobes in order. It tracks PC and retired-instruction count, and sits between instruction memory and the decoder/ALU/register file.

---
 rtl/instr_sequencer.sv | 136 +++++++++++++
 tb/tb_instr_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer sitting between instruction memory and the
// decoder / ALU / register file. Fetches one instruction at a time, latches the
// decoded controls, then steps through read, execute and write-back strobes.
module instr_sequencer #(
    parameter int unsigned        ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    // instruction memory
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    // decoder
    output logic [31:0]       ir,
    input  logic              dec_alu_src,
    input  logic [1:0]        dec_alu_op,
    input  logic [3:0]        dec_reg1,
    input  logic [3:0]        dec_reg2,
    input  logic [3:0]        dec_reg_dest,
    // register file read
    output logic              rf_rd_en,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    // ALU
    output logic              alu_start,
    output logic              alu_src_q,
    output logic [1:0]        alu_op_q,
    input  logic              alu_done,
    // register file write-back
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    // status
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StRead,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam logic [31:0] InstrNop  = 32'h0000_0000;
    localparam logic [31:0] InstrHalt = 32'hFFFF_FFFF;

    state_e state_q;
    state_e state_d;

    // Fetch address is always the PC; both are held while waiting for imem_ready.
    assign imem_addr = pc;

    // Next-state selection; run is only consulted at instruction boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (run) state_d = StFetch;
            StFetch:  if (imem_ready) state_d = StDecode;
            StDecode: begin
                if (ir == InstrNop) begin
                    state_d = run ? StFetch : StIdle;
                end else if (ir == InstrHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StRead;
                end
            end
            StRead:   state_d = StExec;
            StExec:   if (alu_done) state_d = StWb;
            StWb:     state_d = run ? StFetch : StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // State, datapath registers and strobes; strobes are registered from the
    // next state so each one is high exactly while its state is current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc        <= RESET_PC;
            ir        <= '0;
            retired   <= '0;
            alu_src_q <= 1'b0;
            alu_op_q  <= '0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            rf_waddr  <= '0;
            imem_req  <= 1'b0;
            rf_rd_en  <= 1'b0;
            alu_start <= 1'b0;
            rf_we     <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == StFetch && imem_ready) begin
                ir <= imem_rdata;
                pc <= pc + ADDR_W'(1);
            end

            if (state_q == StDecode) begin
                alu_src_q <= dec_alu_src;
                alu_op_q  <= dec_alu_op;
                rf_raddr1 <= dec_reg1;
                rf_raddr2 <= dec_reg2;
                rf_waddr  <= dec_reg_dest;
            end

            // NOPs retire straight out of DECODE; halt words never retire.
            if ((state_q == StDecode && ir == InstrNop) || state_q == StWb) begin
                retired <= retired + CNT_W'(1);
            end

            imem_req  <= (state_d == StFetch);
            rf_rd_en  <= (state_d == StRead);
            // Only the READ->EXEC transition starts the ALU, so a long EXEC
            // still produces a single start pulse.
            alu_start <= (state_d == StExec) && (state_q != StExec);
            rf_we     <= (state_d == StWb);
            busy      <= (state_d != StIdle) && (state_d != StHalt);
            halted    <= (state_d == StHalt);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program with a write-back scoreboard plus
// a second, narrow instance for PC / retired-counter wrap.
module tb_instr_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [3:0] waddr;
        logic [3:0] raddr1;
        logic [3:0] raddr2;
        logic [1:0] op;
        logic       src;
    } wb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, run;
    logic              imem_req, imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata, ir;
    logic              dec_alu_src;
    logic [1:0]        dec_alu_op;
    logic [3:0]        dec_reg1, dec_reg2, dec_reg_dest;
    logic              rf_rd_en, alu_start, alu_src_q, alu_done, rf_we;
    logic [3:0]        rf_raddr1, rf_raddr2, rf_waddr;
    logic [1:0]        alu_op_q;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  retired;
    logic              busy, halted;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    wb_t sb[$];

    // Stand-in decoder: fixed field positions.
    assign dec_alu_op   = ir[31:30];
    assign dec_alu_src  = ir[28];
    assign dec_reg_dest = ir[23:20];
    assign dec_reg1     = ir[7:4];
    assign dec_reg2     = ir[3:0];
    assign imem_rdata   = mem[imem_addr];

    instr_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(8'd0), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ir(ir),
        .dec_alu_src(dec_alu_src), .dec_alu_op(dec_alu_op), .dec_reg1(dec_reg1),
        .dec_reg2(dec_reg2), .dec_reg_dest(dec_reg_dest),
        .rf_rd_en(rf_rd_en), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .alu_start(alu_start), .alu_src_q(alu_src_q), .alu_op_q(alu_op_q),
        .alu_done(alu_done), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .pc(pc), .retired(retired), .busy(busy), .halted(halted)
    );

    // Narrow instance: always-ready memory full of NOPs.
    logic        w_rst_n, w_run;
    logic        w_imem_req, w_rf_rd_en, w_alu_start, w_src, w_we, w_busy, w_halted;
    logic [3:0]  w_imem_addr, w_pc, w_retired, w_raddr1, w_raddr2, w_waddr;
    logic [31:0] w_ir;
    logic [1:0]  w_op;

    instr_sequencer #(.ADDR_W(4), .RESET_PC(4'd15), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .run(w_run),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(1'b1),
        .imem_rdata(32'h0), .ir(w_ir),
        .dec_alu_src(1'b0), .dec_alu_op(2'b00), .dec_reg1(4'h0),
        .dec_reg2(4'h0), .dec_reg_dest(4'h0),
        .rf_rd_en(w_rf_rd_en), .rf_raddr1(w_raddr1), .rf_raddr2(w_raddr2),
        .alu_start(w_alu_start), .alu_src_q(w_src), .alu_op_q(w_op),
        .alu_done(1'b0), .rf_we(w_we), .rf_waddr(w_waddr),
        .pc(w_pc), .retired(w_retired), .busy(w_busy), .halted(w_halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory and ALU responders with programmable latency.
    int fetch_wait = 0, alu_wait = 0, wcnt = 0, ecnt = 0;
    bit in_exec = 0, hold_ready = 0;
    always @(negedge clk) begin
        if (hold_ready) begin
            imem_ready = 1'b1;
        end else if (imem_req) begin
            if (wcnt >= fetch_wait) begin
                imem_ready = 1'b1;
                wcnt = 0;
            end else begin
                imem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ready = 1'b0;
            wcnt = 0;
        end
        if (!rst_n) begin
            in_exec  = 0;
            alu_done = 1'b0;
        end else begin
            if (alu_start) begin
                in_exec = 1;
                ecnt = 0;
            end
            if (in_exec) begin
                if (ecnt >= alu_wait) begin
                    alu_done = 1'b1;
                    in_exec = 0;
                end else begin
                    alu_done = 1'b0;
                    ecnt++;
                end
            end else begin
                alu_done = 1'b0;
            end
        end
    end

    // Write-back monitor: every rf_we must match the next expected record.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: rf_we with waddr %0d, expected no write-back",
                         rf_waddr);
            end else begin
                wb_t exp_wb;
                exp_wb = sb.pop_front();
                check("wb_fields", {rf_waddr, rf_raddr1, rf_raddr2, alu_op_q, alu_src_q}, exp_wb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, starts, rds, wes, addr_bad, ncnt;
        bit seen, req_seen, found, we_seen, wrapped;
        logic [3:0] prev;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h2135_0001;
        mem[1] = 32'hD0A0_0045;
        mem[2] = 32'h0000_0000;
        mem[3] = 32'hFFFF_FFFF;
        rst_n = 1'b0; run = 1'b0; hold_ready = 1; imem_ready = 1'b1; alu_done = 1'b0;
        w_rst_n = 1'b0; w_run = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_pc_ir_ret", {pc, ir, retired}, '0);
        check("rst_busy_halt", {busy, halted}, 2'b00);
        check("rst_strobes", {rf_rd_en, alu_start, rf_we}, 3'b000);
        check("rst_latched", {alu_src_q, alu_op_q, rf_raddr1, rf_raddr2, rf_waddr}, '0);

        // ADD, zero wait, run dropped during EXEC
        hold_ready = 0;
        sb.push_back('{waddr: 4'd3, raddr1: 4'd0, raddr2: 4'd1, op: 2'b00, src: 1'b0});
        run = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("add_c1_req", {imem_req, imem_addr}, {1'b1, 8'd0});
        @(negedge clk);
        check("add_c2_ir_pc", {ir, pc}, {32'h2135_0001, 8'd1});
        @(negedge clk);
        check("add_c3_read", {rf_rd_en, alu_start, rf_raddr1, rf_raddr2}, {1'b1, 1'b0, 4'd0, 4'd1});
        @(negedge clk);
        check("add_c4_exec", {alu_start, rf_rd_en, rf_we}, 3'b100);
        run = 1'b0;
        @(negedge clk);
        check("add_c5_wb", {rf_we, rf_waddr, alu_start, retired}, {1'b1, 4'd3, 1'b0, 16'd0});
        @(negedge clk);
        check("add_c6_idle", {busy, imem_req, rf_we, retired, pc}, {3'b000, 16'd1, 8'd1});
        repeat (2) @(negedge clk);
        check("add_stays_idle", {busy, imem_req}, 2'b00);

        // Wait states: 3 fetch waits, 2 ALU waits -> 10 busy cycles
        fetch_wait = 3; alu_wait = 2;
        sb.push_back('{waddr: 4'd10, raddr1: 4'd4, raddr2: 4'd5, op: 2'b11, src: 1'b1});
        cyc = 0; starts = 0; rds = 0; wes = 0; addr_bad = 0; seen = 0;
        run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                cyc++;
            end
            if (imem_req && imem_addr != 8'd1) addr_bad++;
            starts += int'(alu_start);
            rds += int'(rf_rd_en);
            wes += int'(rf_we);
            if (rf_we) run = 1'b0;
            if (seen && !busy) break;
        end
        check("ws_cycles", cyc, 10);
        check("ws_alu_start_once", starts, 1);
        check("ws_rd_we_once", {rds[7:0], wes[7:0]}, {8'd1, 8'd1});
        check("ws_addr_stable", addr_bad, 0);
        check("ws_pc_retired", {pc, retired}, {8'd2, 16'd2});

        // NOP then HALT
        fetch_wait = 0; alu_wait = 0;
        ncnt = 0;
        run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy && retired == 16'd2) ncnt++;
            if (halted) break;
        end
        check("nop_cycles", ncnt, 2);
        check("halt_flags", {halted, busy}, 2'b10);
        check("halt_pc_retired", {pc, retired}, {8'd4, 16'd3});
        req_seen = 0;
        repeat (6) begin
            @(negedge clk);
            req_seen |= imem_req;
        end
        check("halt_sticky", {req_seen, halted}, 2'b01);

        // Reset during EXEC
        rst_n = 1'b0; run = 1'b0;
        @(negedge clk);
        check("rst_clears_halt", {halted, busy, pc}, {2'b00, 8'd0});
        alu_wait = 6;
        rst_n = 1'b1; run = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (alu_start) begin
                found = 1;
                break;
            end
        end
        check("mid_exec_reached", found, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_exec_abort",
              {busy, rf_we, imem_req, alu_start, halted, pc, retired, ir},
              {5'b00000, 8'd0, 16'd0, 32'd0});
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        we_seen = 0;
        repeat (10) begin
            @(negedge clk);
            we_seen |= rf_we;
        end
        check("mid_exec_no_wb", {we_seen, busy}, 2'b00);

        // PC and retired-counter wrap on the 4-bit instance
        w_run = 1'b1;
        w_rst_n = 1'b1;
        @(negedge clk);
        check("wrap_pc_start", {w_imem_req, w_pc}, {1'b1, 4'd15});
        @(negedge clk);
        check("wrap_pc_to_0", w_pc, 4'd0);
        prev = w_retired;
        wrapped = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (prev == 4'd15 && w_retired == 4'd0) begin
                wrapped = 1;
                break;
            end
            prev = w_retired;
        end
        w_run = 1'b0;
        check("wrap_retired", wrapped, 1'b1);
        check("wrap_pc_after16", {w_pc, w_busy, w_halted}, {4'd15, 2'b10});

        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
